// File: rtl/veda_regfile.sv
// rtl/veda_regfile.sv - NRP-read/1-write register file with byte enables and a self-timed clear sweep
// Optional macro REGFILE_BYPASS_EN: same-edge read of the write address returns the merged write data.
module veda_regfile #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [DW/8-1:0]     wbe,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*DW-1:0]   rdata,
    output logic [NRP-1:0]      rvalid,
    input  logic                clr_req,
    output logic                busy
);
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic [NRP*DW-1:0]   rdata_q;
    logic [NRP-1:0]      rvalid_q;
    logic [DW-1:0]       rd_word [NRP];
    logic                wr_accept;

    assign busy      = (state_q == CLEAR);
    assign wr_accept = (state_q == IDLE) && we && !clr_req;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == {AW{1'b1}}) state_d = IDLE;
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // The array has no reset; the sweep zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DW-1:0] wmerge;
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            wmerge[8*b +: 8] = wbe[b] ? wdata[8*b +: 8] : mem_q[waddr][8*b +: 8];
        end
    end

    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            rd_word[p] = mem_q[raddr[p*AW +: AW]];
            if (wr_accept && (raddr[p*AW +: AW] == waddr)) rd_word[p] = wmerge;
        end
    end
`else
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            rd_word[p] = mem_q[raddr[p*AW +: AW]];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            for (int p = 0; p < NRP; p++) begin
                rvalid_q[p] <= rd_en[p];
                if (rd_en[p]) rdata_q[p*DW +: DW] <= busy ? '0 : rd_word[p];
            end
        end
    end
endmodule

// File: tb/tb_veda_regfile.sv
// tb/tb_veda_regfile.sv - self-checking bench for veda_regfile against a behavioural model
module tb_veda_regfile;
    localparam int DW = 32, AW = 4, NRP = 2, DEPTH = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [1:0]  rd_en;
    logic [7:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        clr_req;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mdl_mem [DEPTH];
    int          clr_left;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rvalid;
    logic        exp_busy;

    always #5 clk = ~clk;

    veda_regfile #(.DW(DW), .AW(AW), .NRP(NRP)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .clr_req(clr_req), .busy(busy)
    );

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        clr_left   = DEPTH;
        exp_rdata  = '0;
        exp_rvalid = '0;
        exp_busy   = 1'b1;
    endtask

    // Applies current inputs to the model, clocks one edge, then idles the inputs.
    task automatic cycle();
        bit          bsy;
        bit          wacc;
        logic [31:0] merged;
        logic [3:0]  a;
        bsy    = (clr_left > 0);
        wacc   = !bsy && we && !clr_req;
        merged = mdl_mem[waddr];
        for (int b = 0; b < 4; b++) if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        for (int p = 0; p < NRP; p++) begin
            exp_rvalid[p] = rd_en[p];
            if (rd_en[p]) begin
                a = raddr[4*p +: 4];
                if (bsy) exp_rdata[32*p +: 32] = '0;
                else if (BYP && wacc && a == waddr) exp_rdata[32*p +: 32] = merged;
                else exp_rdata[32*p +: 32] = mdl_mem[a];
            end
        end
        if (bsy) clr_left--;
        else if (clr_req) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            clr_left = DEPTH;
        end else if (wacc) mdl_mem[waddr] = merged;
        exp_busy = (clr_left > 0);
        @(posedge clk);
        #1;
        we = 1'b0; rd_en = '0; clr_req = 1'b0; wbe = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        rd_en = '0; raddr = '0; clr_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (rdata !== 64'h0 || rvalid !== 2'b00 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: rdata=%h rvalid=%b busy=%b, wanted 0/00/1", rdata, rvalid, busy);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            n_cmp++;
            if (busy !== exp_busy || busy !== (i < DEPTH)) begin
                n_fail++;
                $display("FAIL reset_sweep edge %0d: busy=%b wanted %b", i, busy, exp_busy);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 2'b11; raddr = {4'(DEPTH-1-i), 4'(i)};
            cycle();
            n_cmp++;
            if (rdata !== exp_rdata || rvalid !== exp_rvalid || rdata !== 64'h0 || rvalid !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_readback addr %0d: rdata=%h rvalid=%b wanted %h/%b", i, rdata, rvalid, exp_rdata, exp_rvalid);
            end
        end
    endtask

    task automatic test_byte_enable();
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; wbe = 4'hF; cycle();
        we = 1'b1; waddr = 4'd3; wdata = 32'h11223344; wbe = 4'b0101; cycle();
        rd_en = 2'b01; raddr = 8'h03; cycle();
        n_cmp++;
        if (rdata[31:0] !== 32'hDE22BE44 || rdata !== exp_rdata || rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL byte_enable: rdata0=%h rvalid=%b wanted DE22BE44/01", rdata[31:0], rvalid);
        end
    endtask

    task automatic test_same_edge();
        we = 1'b1; waddr = 4'd5; wdata = 32'hCAFEF00D; wbe = 4'hF;
        rd_en = 2'b01; raddr = 8'h05; cycle();
        n_cmp++;
        if (rdata[31:0] !== (BYP ? 32'hCAFEF00D : 32'h0) || rdata !== exp_rdata || rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL same_edge: rdata0=%h rvalid=%b wanted %h/01", rdata[31:0], rvalid, exp_rdata[31:0]);
        end
        rd_en = 2'b01; raddr = 8'h05; cycle();
        n_cmp++;
        if (rdata[31:0] !== 32'hCAFEF00D || rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL next_edge_read: rdata0=%h rvalid=%b wanted CAFEF00D/01", rdata[31:0], rvalid);
        end
    endtask

    task automatic test_dual_port();
        we = 1'b1; waddr = 4'd1; wdata = 32'hA1; wbe = 4'hF; cycle();
        we = 1'b1; waddr = 4'd2; wdata = 32'hB2; wbe = 4'hF; cycle();
        rd_en = 2'b11; raddr = {4'd2, 4'd1}; cycle();
        n_cmp++;
        if (rdata !== {32'hB2, 32'hA1} || rvalid !== 2'b11) begin
            n_fail++;
            $display("FAIL dual_port: rdata=%h rvalid=%b wanted 000000B2000000A1/11", rdata, rvalid);
        end
        cycle();
        n_cmp++;
        if (rdata !== {32'hB2, 32'hA1} || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL dual_port_hold: rdata=%h rvalid=%b wanted 000000B2000000A1/00", rdata, rvalid);
        end
    endtask

    task automatic test_clear();
        int fall;
        fall = 0;
        we = 1'b1; waddr = 4'd7; wdata = 32'h77777777; wbe = 4'hF; cycle();
        clr_req = 1'b1; we = 1'b1; waddr = 4'd7; wdata = 32'h12345678; wbe = 4'hF; cycle();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_start: busy=%b wanted 1", busy);
        end
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin rd_en = 2'b10; raddr = {4'd7, 4'd0}; end
            if (k == 8) clr_req = 1'b1;
            cycle();
            if (!busy && fall == 0) fall = k;
            if (k == 3) begin
                n_cmp++;
                if (rdata[63:32] !== 32'h0 || rvalid !== 2'b10) begin
                    n_fail++;
                    $display("FAIL clear_busy_read: rdata1=%h rvalid=%b wanted 0/10", rdata[63:32], rvalid);
                end
            end
        end
        n_cmp++;
        if (fall != DEPTH) begin
            n_fail++;
            $display("FAIL clear_duration: busy fell at edge %0d wanted %0d", fall, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 2'b11; raddr = {4'(i), 4'(i)};
            cycle();
            n_cmp++;
            if (rdata !== 64'h0 || rvalid !== 2'b11) begin
                n_fail++;
                $display("FAIL clear_readback addr %0d: rdata=%h rvalid=%b wanted 0/11", i, rdata, rvalid);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int fall;
        fall = 0;
        we = 1'b1; waddr = 4'd9; wdata = 32'h5A5A5A5A; wbe = 4'hF; cycle();
        rd_en = 2'b01; raddr = 8'h09; cycle();
        clr_req = 1'b1; cycle();
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) begin rd_en = 2'b10; raddr = 8'h90; end
            cycle();
        end
        n_cmp++;
        if (rdata[31:0] !== 32'h5A5A5A5A || rvalid !== 2'b10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: rdata0=%h rvalid=%b busy=%b wanted 5A5A5A5A/10/1", rdata[31:0], rvalid, busy);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdata !== 64'h0 || rvalid !== 2'b00 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_reset: rdata=%h rvalid=%b busy=%b wanted 0/00/1", rdata, rvalid, busy);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (!busy && fall == 0) fall = k;
        end
        n_cmp++;
        if (fall != DEPTH) begin
            n_fail++;
            $display("FAIL restart_duration: busy fell at edge %0d wanted %0d", fall, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we      = 1'($urandom);
            waddr   = 4'($urandom);
            wdata   = $urandom;
            wbe     = 4'($urandom);
            rd_en   = 2'($urandom);
            raddr   = ($urandom % 3 == 0) ? {waddr, waddr} : 8'($urandom);
            clr_req = ($urandom % 40 == 0);
            cycle();
            n_cmp++;
            if (rdata !== exp_rdata || rvalid !== exp_rvalid || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random step %0d: rdata=%h rvalid=%b busy=%b wanted %h/%b/%b",
                         i, rdata, rvalid, busy, exp_rdata, exp_rvalid, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_same_edge();
        test_dual_port();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
